// File: rtl/class_sum_scheduler.sv
// class_sum_scheduler
// Sequences one Tsetlin Machine inference through the class-vote datapath.
// Clause-output beats are folded into a signed per-class vote. Each finished
// class total goes to argmax as a one-cycle argmax_ena strobe. Once argmax
// reports done, a one-cycle infer_done pulse is sent upstream.
// Optional feature: define CLASS_SUM_SAT_EN to make the accumulator saturate
// instead of wrap. This build also adds a sticky sat_flag output.
module class_sum_scheduler #(
    parameter int LANES  = 8,
    parameter int SUM_W  = 14,
    parameter int BEAT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clause_valid,
    output logic                     clause_ready,
    input  logic [LANES-1:0]         clause_out,
    input  logic [3:0]               SPI_NUM_CLASS,
    input  logic [BEAT_W-1:0]        SPI_NUM_BEAT,
    output logic                     argmax_ena,
    output logic [SUM_W-1:0]         class_summation,
    output logic [3:0]               class_idx,
    input  logic                     argmax_done,
    output logic                     busy,
    output logic                     infer_done
`ifdef CLASS_SUM_SAT_EN
   ,output logic                     sat_flag
`endif
);

    // Width of a per-polarity popcount and of the signed per-beat vote.
    localparam int CNT_W  = $clog2(LANES / 2 + 1);
    localparam int VOTE_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_EMIT,
        S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic signed [SUM_W-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [3:0]              class_cnt_q, class_cnt_d;
    logic [3:0]              num_class_q, num_class_d;
    logic [BEAT_W-1:0]       num_beat_q, num_beat_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [3:0]              idx_q, idx_d;
    logic                    infer_done_q, infer_done_d;

    logic [CNT_W-1:0]        pos_cnt;
    logic [CNT_W-1:0]        neg_cnt;
    logic signed [VOTE_W-1:0] beat_vote;
    logic signed [SUM_W:0]   sum_wide;
    logic signed [SUM_W-1:0] acc_sum;
    logic                    last_beat;
    logic                    last_class;

`ifdef CLASS_SUM_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {1'b1, {(SUM_W-1){1'b0}}};

    logic                    sat_flag_q, sat_flag_d;
    logic                    clamp_hit;
`endif

    // Popcount of the positive (even) and negative (odd) clause lanes of the current beat.
    always_comb begin
        pos_cnt = '0;
        neg_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            if (clause_out[i]) begin
                if ((i % 2) == 0) begin
                    pos_cnt = pos_cnt + CNT_W'(1);
                end else begin
                    neg_cnt = neg_cnt + CNT_W'(1);
                end
            end
        end
    end

    // The signed vote of one beat lies in [-LANES/2, LANES/2].
    // It is added one bit wider than the accumulator, so any overflow shows up as a sign disagreement.
    assign beat_vote = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
    assign sum_wide  = {acc_q[SUM_W-1], acc_q}
                     + {{(SUM_W + 1 - VOTE_W){beat_vote[VOTE_W-1]}}, beat_vote};

`ifdef CLASS_SUM_SAT_EN
    // Clamp the new accumulator value to the signed range and flag the clamp.
    always_comb begin
        clamp_hit = 1'b0;
        acc_sum   = sum_wide[SUM_W-1:0];
        if (sum_wide[SUM_W] != sum_wide[SUM_W-1]) begin
            clamp_hit = 1'b1;
            acc_sum   = sum_wide[SUM_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign acc_sum = sum_wide[SUM_W-1:0];
`endif

    // A latched count of zero stands for the full range.
    // Comparing against count-1 in the counter's own width handles that case for free.
    assign last_beat  = (beat_cnt_q == (num_beat_q - BEAT_W'(1)));
    assign last_class = (class_cnt_q == (num_class_q - 4'd1));

    // State and datapath registers.
    // Reset is synchronous and also aborts an inference in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            beat_cnt_q   <= '0;
            class_cnt_q  <= '0;
            num_class_q  <= '0;
            num_beat_q   <= '0;
            sum_q        <= '0;
            idx_q        <= '0;
            infer_done_q <= 1'b0;
`ifdef CLASS_SUM_SAT_EN
            sat_flag_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            beat_cnt_q   <= beat_cnt_d;
            class_cnt_q  <= class_cnt_d;
            num_class_q  <= num_class_d;
            num_beat_q   <= num_beat_d;
            sum_q        <= sum_d;
            idx_q        <= idx_d;
            infer_done_q <= infer_done_d;
`ifdef CLASS_SUM_SAT_EN
            sat_flag_q   <= sat_flag_d;
`endif
        end
    end

    // Next-state logic.
    // The class total and index are loaded on the final beat, so they are already valid during the EMIT cycle.
    // They then hold until the next strobe.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        beat_cnt_d   = beat_cnt_q;
        class_cnt_d  = class_cnt_q;
        num_class_d  = num_class_q;
        num_beat_d   = num_beat_q;
        sum_d        = sum_q;
        idx_d        = idx_q;
        infer_done_d = 1'b0;
`ifdef CLASS_SUM_SAT_EN
        sat_flag_d   = sat_flag_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ACCUM;
                    acc_d       = '0;
                    beat_cnt_d  = '0;
                    class_cnt_d = '0;
                    num_class_d = SPI_NUM_CLASS;
                    num_beat_d  = SPI_NUM_BEAT;
`ifdef CLASS_SUM_SAT_EN
                    sat_flag_d  = 1'b0;
`endif
                end
            end

            S_ACCUM: begin
                if (clause_valid) begin
                    acc_d      = acc_sum;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
`ifdef CLASS_SUM_SAT_EN
                    if (clamp_hit) begin
                        sat_flag_d = 1'b1;
                    end
`endif
                    if (last_beat) begin
                        state_d = S_EMIT;
                        sum_d   = acc_sum;
                        idx_d   = class_cnt_q;
                    end
                end
            end

            S_EMIT: begin
                if (last_class) begin
                    state_d = S_WAIT;
                end else begin
                    state_d     = S_ACCUM;
                    class_cnt_d = class_cnt_q + 4'd1;
                    acc_d       = '0;
                    beat_cnt_d  = '0;
                end
            end

            S_WAIT: begin
                if (argmax_done) begin
                    state_d      = S_IDLE;
                    infer_done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign clause_ready    = (state_q == S_ACCUM);
    assign argmax_ena      = (state_q == S_EMIT);
    assign busy            = (state_q != S_IDLE);
    assign class_summation = sum_q;
    assign class_idx       = idx_q;
    assign infer_done      = infer_done_q;
`ifdef CLASS_SUM_SAT_EN
    assign sat_flag        = sat_flag_q;
`endif

endmodule

// File: tb/tb_class_sum_scheduler.sv
// tb_class_sum_scheduler
// Drives two schedulers from the same stimulus: a full-width one (SUM_W=14)
// and a narrow one (SUM_W=6). The narrow one exercises wrap or saturation.
// Expected class totals are computed from the voting rule with plain integer
// arithmetic. The rule: even lanes vote +1 and odd lanes vote -1.
// Honours CLASS_SUM_SAT_EN.
module tb_class_sum_scheduler;

    localparam int LANES   = 8;
    localparam int SUM_W_A = 14;
    localparam int SUM_W_B = 6;
    localparam int BEAT_W  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clauseValid;
    logic [7:0]  clauseOut;
    logic [3:0]  spiNumClass;
    logic [7:0]  spiNumBeat;
    logic        argmaxDone;

    logic        readyA, readyB, enaA, enaB, busyA, busyB, doneA, doneB;
    logic [13:0] sumA;
    logic [5:0]  sumB;
    logic [3:0]  idxA, idxB;
`ifdef CLASS_SUM_SAT_EN
    logic        satA, satB;
`endif

    int assertCount = 0;
    int failCount   = 0;
    int cycleCnt    = 0;

    // Reference accumulators and sticky clamp flags for both widths.
    int accA, accB;
    bit satExpA, satExpB;

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency checks.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    class_sum_scheduler #(.LANES(LANES), .SUM_W(SUM_W_A), .BEAT_W(BEAT_W)) dutA (
        .clk(clk), .rst(rst), .start(start), .clause_valid(clauseValid),
        .clause_ready(readyA), .clause_out(clauseOut), .SPI_NUM_CLASS(spiNumClass),
        .SPI_NUM_BEAT(spiNumBeat), .argmax_ena(enaA), .class_summation(sumA),
        .class_idx(idxA), .argmax_done(argmaxDone), .busy(busyA), .infer_done(doneA)
`ifdef CLASS_SUM_SAT_EN
       ,.sat_flag(satA)
`endif
    );

    class_sum_scheduler #(.LANES(LANES), .SUM_W(SUM_W_B), .BEAT_W(BEAT_W)) dutB (
        .clk(clk), .rst(rst), .start(start), .clause_valid(clauseValid),
        .clause_ready(readyB), .clause_out(clauseOut), .SPI_NUM_CLASS(spiNumClass),
        .SPI_NUM_BEAT(spiNumBeat), .argmax_ena(enaB), .class_summation(sumB),
        .class_idx(idxB), .argmax_done(argmaxDone), .busy(busyB), .infer_done(doneB)
`ifdef CLASS_SUM_SAT_EN
       ,.sat_flag(satB)
`endif
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and on mismatch count and report the failure.
    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one clause beat, or idle the bus.
    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        clauseValid = valid;
        clauseOut   = data;
    endtask

    // The vote of one beat is the count of set even lanes minus the count of set odd lanes.
    function automatic int beatVote(input logic [7:0] d);
        int v;
        v = 0;
        for (int i = 0; i < LANES; i++) begin
            if (d[i]) v += ((i % 2) == 0) ? 1 : -1;
        end
        return v;
    endfunction

    // Two's-complement wrap of an integer into a w-bit signed range.
    function automatic int wrapTo(input int v, input int w);
        int m;
        int r;
        m = 1 << w;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic int hiOf(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int loOf(input int w);
        return -(1 << (w - 1));
    endfunction

    // Fold one beat's vote into both reference accumulators.
    task automatic modelBeat(input int v);
        int rawA;
        int rawB;
        rawA = accA + v;
        rawB = accB + v;
`ifdef CLASS_SUM_SAT_EN
        if (rawA > hiOf(SUM_W_A)) begin rawA = hiOf(SUM_W_A); satExpA = 1'b1; end
        if (rawA < loOf(SUM_W_A)) begin rawA = loOf(SUM_W_A); satExpA = 1'b1; end
        if (rawB > hiOf(SUM_W_B)) begin rawB = hiOf(SUM_W_B); satExpB = 1'b1; end
        if (rawB < loOf(SUM_W_B)) begin rawB = loOf(SUM_W_B); satExpB = 1'b1; end
`else
        rawA = wrapTo(rawA, SUM_W_A);
        rawB = wrapTo(rawB, SUM_W_B);
`endif
        accA = rawA;
        accB = rawB;
    endtask

    // Beat pattern per mode:
    // 0: all 0x55; 1: alternating 0xFF/0xAA; 3: all 0xAA; otherwise random.
    function automatic logic [7:0] genBeat(input int mode, input int b);
        case (mode)
            0:       return 8'h55;
            1:       return ((b % 2) == 0) ? 8'hFF : 8'hAA;
            3:       return 8'hAA;
            default: return 8'($urandom);
        endcase
    endfunction

    // Run one complete inference and check every strobe, the handshakes, the latency and the done pulse.
    // A stall of stallLen idle cycles is inserted before beat stallBeat of class stallClass.
    // pokeStart raises start (with new config) during the first beat of class 1.
    task automatic runInference(input int nc, input int nb, input int mode, input int stallClass,
                                input int stallBeat, input int stallLen, input int doneDelay,
                                input bit pokeStart);
        int ncEff;
        int nbEff;
        int startCycle;
        int stallSeen;
        logic [7:0] data;
        ncEff     = (nc == 0) ? 16 : nc;
        nbEff     = (nb == 0) ? 256 : nb;
        stallSeen = 0;
        satExpA   = 1'b0;
        satExpB   = 1'b0;

        spiNumClass = 4'(nc);
        spiNumBeat  = 8'(nb);
        start       = 1'b1;
        startCycle  = cycleCnt;
        tick();
        start       = 1'b0;
        spiNumClass = 4'($urandom);
        spiNumBeat  = 8'($urandom);
        checkOutput("busyAfterStart", 32'(busyA), 1);
        checkOutput("readyAfterStart", 32'(readyA), 1);
        checkOutput("readyAfterStartB", 32'(readyB & busyB), 1);
`ifdef CLASS_SUM_SAT_EN
        checkOutput("satClearedOnStart", 32'(satA | satB), 0);
`endif

        for (int k = 0; k < ncEff; k++) begin
            accA = 0;
            accB = 0;
            for (int b = 0; b < nbEff; b++) begin
                if (k == stallClass && b == stallBeat) begin
                    for (int s = 0; s < stallLen; s++) begin
                        applyStimulus(1'b0, 8'($urandom));
                        tick();
                        checkOutput("stallNoEna", 32'(enaA), 0);
                        checkOutput("stallReady", 32'(readyA), 1);
                    end
                    stallSeen = stallLen;
                end
                if (pokeStart && k == 1 && b == 0) start = 1'b1;
                data = genBeat(mode, b);
                applyStimulus(1'b1, data);
                modelBeat(beatVote(data));
                tick();
                start = 1'b0;
                applyStimulus(1'b0, 8'h00);
                if (b != nbEff - 1) begin
                    checkOutput("midClassNoEna", 32'(enaA | enaB), 0);
                    checkOutput("midClassReady", 32'(readyA), 1);
                end
            end
            checkOutput("emitEna", 32'(enaA), 1);
            checkOutput("emitEnaB", 32'(enaB), 1);
            checkOutput("emitReadyLow", 32'(readyA), 0);
            checkOutput("emitSumA", 32'($signed(sumA)), accA);
            checkOutput("emitSumB", 32'($signed(sumB)), accB);
            checkOutput("emitIdxA", 32'(idxA), k);
            checkOutput("emitIdxB", 32'(idxB), k);
            tick();
            if (k < ncEff - 1) begin
                checkOutput("nextClassReady", 32'(readyA), 1);
                checkOutput("nextClassNoEna", 32'(enaA), 0);
            end
        end

        checkOutput("waitNoEna", 32'(enaA), 0);
        checkOutput("waitBusy", 32'(busyA), 1);
        checkOutput("waitReadyLow", 32'(readyA), 0);
        checkOutput("waitSumHold", 32'($signed(sumA)), accA);
        for (int d = 0; d < doneDelay; d++) begin
            tick();
            checkOutput("waitNoDone", 32'(doneA), 0);
        end
        argmaxDone = 1'b1;
        tick();
        argmaxDone = 1'b0;
        checkOutput("inferDone", 32'(doneA), 1);
        checkOutput("inferDoneB", 32'(doneB), 1);
        checkOutput("idleAfterDone", 32'(busyA), 0);
        checkOutput("latency", cycleCnt - startCycle,
                    ncEff * (nbEff + 1) + 2 + stallSeen + doneDelay);
`ifdef CLASS_SUM_SAT_EN
        checkOutput("satFlagA", 32'(satA), 32'(satExpA));
        checkOutput("satFlagB", 32'(satB), 32'(satExpB));
`endif
        tick();
        checkOutput("inferDonePulse", 32'(doneA), 0);
        checkOutput("sumHoldIdle", 32'($signed(sumB)), accB);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        argmaxDone  = 1'b0;
        spiNumClass = 4'd0;
        spiNumBeat  = 8'd0;
        applyStimulus(1'b0, 8'h00);
        tick();
        tick();
        checkOutput("resetBusy", 32'(busyA | busyB), 0);
        checkOutput("resetReady", 32'(readyA), 0);
        checkOutput("resetEna", 32'(enaA), 0);
        checkOutput("resetSum", 32'($signed(sumA)), 0);
        checkOutput("resetIdx", 32'(idxA), 0);
        checkOutput("resetDone", 32'(doneA), 0);
        rst = 1'b0;
        tick();

        $display("[TB] three classes of two 0x55 beats");
        runInference(3, 2, 0, -1, 0, 0, 0, 1'b0);

        $display("[TB] alternating 0xFF/0xAA, four beats");
        runInference(2, 4, 1, -1, 0, 0, 0, 1'b0);

        $display("[TB] five-cycle stall in the middle of class 1");
        runInference(2, 5, 2, 1, 2, 5, 0, 1'b0);

        $display("[TB] reset during class 1");
        spiNumClass = 4'd3;
        spiNumBeat  = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h55);
            tick();
            if (i == 1) begin
                applyStimulus(1'b0, 8'h00);
                tick();
            end
        end
        applyStimulus(1'b0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midResetBusy", 32'(busyA), 0);
        checkOutput("midResetEna", 32'(enaA), 0);
        checkOutput("midResetReady", 32'(readyA), 0);
        checkOutput("midResetSum", 32'($signed(sumA)), 0);
        runInference(2, 3, 2, -1, 0, 0, 1, 1'b0);

        $display("[TB] sixteen classes with start poked while busy");
        runInference(0, 1, 2, -1, 0, 0, 0, 1'b1);

        $display("[TB] twenty 0x55 beats overflow the narrow accumulator");
        runInference(1, 20, 0, -1, 0, 0, 0, 1'b0);

        $display("[TB] negative overflow of the narrow accumulator");
        runInference(1, 10, 3, -1, 0, 0, 0, 1'b0);

        $display("[TB] beat count of zero means 256 beats");
        runInference(1, 0, 2, -1, 0, 0, 0, 1'b0);

        $display("[TB] randomized inferences");
        for (int r = 0; r < 4; r++) begin
            runInference(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 2,
                         int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] start together with reset");
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("startWithRstIdle", 32'(busyA), 0);
        tick();
        checkOutput("startWithRstStillIdle", 32'(busyA | readyA), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
